// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int LINE_WORDS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL_REQ,
    S_REFILL_DATA,
    S_WRITE_REQ
  } state_t;

  // Byte offset within a line: word select plus byte select.
  function automatic int off_w();
    return $clog2(LINE_WORDS * 4);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return 32 - off_w() - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bus of the data cache; slave is the cache view.
interface dcache_if;
  logic [31:0] cpu_addr;
  logic        cpu_re;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_din;
  logic [31:0] cpu_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rnw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_be;
  logic [31:0] mem_rdata;
  logic        mem_rdata_valid;

  modport slave (
    input  cpu_addr, cpu_re, cpu_we, cpu_din, mem_req_ready, mem_rdata, mem_rdata_valid,
    output cpu_dout, stall, mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_data, mem_req_be
  );

  modport master (
    output cpu_addr, cpu_re, cpu_we, cpu_din, mem_req_ready, mem_rdata, mem_rdata_valid,
    input  cpu_dout, stall, mem_req_valid, mem_req_rnw, mem_req_addr, mem_req_data, mem_req_be
  );
endinterface

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read, byte-enabled store port, refill word port.
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int NUM_LINES = 64,
  localparam int IW        = idx_w(NUM_LINES),
  localparam int TW        = tag_w(NUM_LINES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] i_idx,
  input  logic [1:0]    i_word,
  output logic          o_valid,
  output logic [TW-1:0] o_tag,
  output logic [31:0]   o_rdata,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  input  logic          i_fill_we,
  input  logic [1:0]    i_fill_word,
  input  logic [31:0]   i_fill_data,
  input  logic          i_set_valid,
  input  logic [TW-1:0] i_tag,
  input  logic          i_clr_valid
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TW-1:0]        r_tag  [NUM_LINES];
  logic [31:0]          r_data [NUM_LINES][LINE_WORDS];

  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_rdata = r_data[i_idx][i_word];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_set_valid) begin
      r_valid[i_idx] <= 1'b1;
    end else if (i_clr_valid) begin
      r_valid[i_idx] <= 1'b0;
    end
  end

  // Refill and store updates never coincide; refill takes the port when both could.
  always_ff @(posedge clk) begin
    if (i_set_valid) r_tag[i_idx] <= i_tag;
    if (i_fill_we) begin
      r_data[i_idx][i_fill_word] <= i_fill_data;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_data[i_idx][i_word][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word line refill.
module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 64
) (
  input logic     clk,
  input logic     rst,
  dcache_if.slave bus
);

  localparam int IW = idx_w(NUM_LINES);
  localparam int TW = tag_w(NUM_LINES);
  localparam int OW = off_w();

  state_t      r_state;
  logic [31:2] r_waddr;
  logic [31:0] r_din;
  logic [31:0] r_dout;
  logic [3:0]  r_be;
  logic        r_store;
  logic [1:0]  r_cnt;

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [TW-1:0] w_ltag;
  logic [1:0]    w_word;
  logic [31:0]   w_rword;
  logic [3:0]    w_st_be;
  logic          w_valid, w_hit, w_load_hit, w_stall, w_accept, w_beat, w_last, w_clr;

  assign w_idx      = r_waddr[OW +: IW];
  assign w_tag      = r_waddr[31 -: TW];
  assign w_word     = r_waddr[3:2];
  assign w_hit      = w_valid && (w_ltag == w_tag);
  assign w_load_hit = (r_state == S_LOOKUP) && !r_store && w_hit;
  assign w_stall    = (r_state == S_IDLE) ? 1'b0 : !w_load_hit;
  assign w_accept   = !w_stall && (bus.cpu_re || (bus.cpu_we != 4'b0));
  assign w_beat     = (r_state == S_REFILL_DATA) && bus.mem_rdata_valid;
  assign w_last     = w_beat && (r_cnt == 2'd3);
  // The line is invalidated as soon as a refill starts so an aborted fill never looks valid.
  assign w_clr      = (r_state == S_LOOKUP) && !r_store && !w_hit;
  assign w_st_be    = ((r_state == S_WRITE_REQ) && bus.mem_req_ready && w_hit) ? r_be : 4'b0;

  dcache_array #(.NUM_LINES(NUM_LINES)) u_array (
    .clk        (clk),
    .rst        (rst),
    .i_idx      (w_idx),
    .i_word     (w_word),
    .o_valid    (w_valid),
    .o_tag      (w_ltag),
    .o_rdata    (w_rword),
    .i_be       (w_st_be),
    .i_wdata    (r_din),
    .i_fill_we  (w_beat),
    .i_fill_word(r_cnt),
    .i_fill_data(bus.mem_rdata),
    .i_set_valid(w_last),
    .i_tag      (w_tag),
    .i_clr_valid(w_clr)
  );

  assign bus.stall    = !rst && w_stall;
  assign bus.cpu_dout = rst ? 32'h0 : (w_load_hit ? w_rword : r_dout);

  always_comb begin
    bus.mem_req_valid = 1'b0;
    bus.mem_req_rnw   = 1'b0;
    bus.mem_req_addr  = 32'h0;
    bus.mem_req_data  = 32'h0;
    bus.mem_req_be    = 4'h0;
    if (!rst && r_state == S_REFILL_REQ) begin
      bus.mem_req_valid = 1'b1;
      bus.mem_req_rnw   = 1'b1;
      bus.mem_req_addr  = {r_waddr[31:4], 4'h0};
    end else if (!rst && r_state == S_WRITE_REQ) begin
      bus.mem_req_valid = 1'b1;
      bus.mem_req_addr  = {r_waddr, 2'b00};
      bus.mem_req_data  = r_din;
      bus.mem_req_be    = r_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_waddr <= '0;
      r_din   <= '0;
      r_be    <= '0;
      r_store <= 1'b0;
      r_cnt   <= '0;
      r_dout  <= '0;
    end else begin
      if (w_accept) begin
        r_waddr <= bus.cpu_addr[31:2];
        r_din   <= bus.cpu_din;
        r_be    <= bus.cpu_we;
        r_store <= (bus.cpu_we != 4'b0);
      end
      unique case (r_state)
        S_IDLE:       if (w_accept) r_state <= S_LOOKUP;
        S_LOOKUP: begin
          if (r_store) begin
            r_state <= S_WRITE_REQ;
          end else if (w_hit) begin
            r_dout  <= w_rword;
            r_state <= w_accept ? S_LOOKUP : S_IDLE;
          end else begin
            r_state <= S_REFILL_REQ;
          end
        end
        S_REFILL_REQ: if (bus.mem_req_ready) begin
          r_state <= S_REFILL_DATA;
          r_cnt   <= '0;
        end
        S_REFILL_DATA: if (bus.mem_rdata_valid) begin
          r_cnt <= r_cnt + 2'd1;
          // Final beat: the requested word is either this beat or already in the array.
          if (r_cnt == 2'd3) begin
            r_dout  <= (w_word == 2'd3) ? bus.mem_rdata : w_rword;
            r_state <= S_IDLE;
          end
        end
        S_WRITE_REQ:  if (bus.mem_req_ready) r_state <= S_IDLE;
        default:      r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: stimulus queues expected loads and memory requests, a monitor checks them.
module tb_dcache;

  localparam int NL = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dcache_if bus();

  dcache #(.NUM_LINES(NL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] lq[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic  pend;
  logic  pw;
  mreq_t prev;
  mreq_t e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not match expectation", name);
  endtask

  // Monitor: load data when a pending load completes, memory requests on handshake.
  initial begin
    pend = 1'b0;
    pw   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        pw   = 1'b0;
        lq.delete();
      end else begin
        if (pend && !bus.stall) begin
          if (lq.size() == 0) fail_now("load_unexpected");
          else chk("load_data", bus.cpu_dout, lq.pop_front());
          pend = 1'b0;
        end
        if (!bus.stall && (bus.cpu_re || bus.cpu_we != 4'b0)) pend = (bus.cpu_we == 4'b0);
        if (bus.mem_req_valid && mq.size() == 0) fail_now("req_unexpected");
        if (pw && bus.mem_req_valid) begin
          chk("req_stable_addr", bus.mem_req_addr, prev.addr);
          chk("req_stable_data", bus.mem_req_data, prev.data);
          chk("req_stable_be", 32'(bus.mem_req_be), 32'(prev.be));
        end
        if (bus.mem_req_valid && bus.mem_req_ready && mq.size() != 0) begin
          e = mq.pop_front();
          chk("req_rnw", 32'(bus.mem_req_rnw), 32'(e.rnw));
          chk("req_addr", bus.mem_req_addr, e.addr);
          if (!e.rnw) begin
            chk("req_data", bus.mem_req_data, e.data);
            chk("req_be", 32'(bus.mem_req_be), 32'(e.be));
          end
        end
        pw        = bus.mem_req_valid && !bus.mem_req_ready;
        prev.addr = bus.mem_req_addr;
        prev.data = bus.mem_req_data;
        prev.be   = bus.mem_req_be;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_free();
    int n = 0;
    while (bus.stall && n < 50) begin
      cyc();
      n++;
    end
    if (bus.stall) fail_now("stall_timeout");
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] exp, input logic miss);
    wait_free();
    lq.push_back(exp);
    if (miss) mq.push_back(mreq_t'{1'b1, {a[31:4], 4'h0}, 32'h0, 4'h0});
    bus.cpu_addr = a;
    bus.cpu_re   = 1'b1;
    cyc();
    bus.cpu_re   = 1'b0;
    chk("lookup_stall", 32'(bus.stall), 32'(miss));
  endtask

  task automatic st(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                    input int delay, input int exp_stall);
    int sc = 0;
    int vc = 0;
    int n  = 0;
    wait_free();
    mq.push_back(mreq_t'{1'b0, {a[31:2], 2'b00}, d, be});
    bus.cpu_addr = a;
    bus.cpu_we   = be;
    bus.cpu_din  = d;
    cyc();
    bus.cpu_we   = 4'b0;
    while (bus.stall && n < 50) begin
      sc++;
      if (bus.mem_req_valid) vc++;
      bus.mem_req_ready = (vc == delay);
      cyc();
      bus.mem_req_ready = 1'b0;
      n++;
    end
    chk("store_stall_cycles", sc, exp_stall);
    chk("store_req_cycles", vc, delay);
  endtask

  task automatic refill(input logic [31:0] base, input int delay, input int nbeats);
    int n = 0;
    while (!bus.mem_req_valid && n < 20) begin
      cyc();
      n++;
    end
    if (!bus.mem_req_valid) fail_now("refill_req_timeout");
    repeat (delay - 1) cyc();
    bus.mem_req_ready = 1'b1;
    cyc();
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = base + i;
      cyc();
    end
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

  initial begin
    bus.cpu_addr        = 32'h0;
    bus.cpu_re          = 1'b0;
    bus.cpu_we          = 4'b0;
    bus.cpu_din         = 32'h0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_rdata       = 32'h0;
    bus.mem_rdata_valid = 1'b0;

    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_req_valid", 32'(bus.mem_req_valid), 32'h0);
    chk("rst_req_rnw", 32'(bus.mem_req_rnw), 32'h0);
    chk("rst_dout", bus.cpu_dout, 32'h0);
    chk("rst_req_addr", bus.mem_req_addr, 32'h0);
    chk("rst_req_data", bus.mem_req_data, 32'h0);
    chk("rst_req_be", 32'(bus.mem_req_be), 32'h0);
    rst = 1'b0;
    cyc();
    chk("post_rst_stall", 32'(bus.stall), 32'h0);
    chk("post_rst_dout", bus.cpu_dout, 32'h0);

    // Cold miss and refill, then back-to-back hits.
    ld(32'h1000_0040, 32'h0000_00A0, 1'b1);
    refill(32'h0000_00A0, 1, 4);
    ld(32'h1000_0044, 32'h0000_00A1, 1'b0);
    ld(32'h1000_004C, 32'h0000_00A3, 1'b0);

    // Store hit with slow memory, then read back merged bytes.
    st(32'h1000_0044, 4'b0011, 32'h0000_BEEF, 3, 4);
    ld(32'h1000_0044, 32'h0000_BEEF, 1'b0);

    // Store miss does not allocate.
    st(32'h1000_0800, 4'b1111, 32'h1234_5678, 1, 2);
    ld(32'h1000_0800, 32'h0000_0050, 1'b1);
    refill(32'h0000_0050, 2, 4);

    // Conflict eviction and requested-word selection on refill.
    ld(32'h1000_0040, 32'h0000_00A0, 1'b0);
    ld(32'h1000_0040 + 16 * NL, 32'h0000_00C0, 1'b1);
    refill(32'h0000_00C0, 1, 4);
    ld(32'h1000_0040, 32'h0000_00D0, 1'b1);
    refill(32'h0000_00D0, 1, 4);
    ld(32'h1000_004C, 32'h0000_00D3, 1'b0);
    ld(32'h1000_0448, 32'h0000_00E2, 1'b1);
    refill(32'h0000_00E0, 1, 4);
    ld(32'h1000_084C, 32'h0000_00F3, 1'b1);
    refill(32'h0000_00F0, 1, 4);
    ld(32'h1000_0800, 32'h0000_0050, 1'b0);

    // Reset in the middle of a refill.
    ld(32'h1000_0400, 32'h0000_0060, 1'b1);
    refill(32'h0000_0060, 1, 2);
    rst = 1'b1;
    cyc();
    chk("abort_stall", 32'(bus.stall), 32'h0);
    chk("abort_req_valid", 32'(bus.mem_req_valid), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.mem_rdata_valid = 1'b1;
      bus.mem_rdata       = 32'h0000_0066;
      cyc();
      chk("stray_beat_stall", 32'(bus.stall), 32'h0);
      chk("stray_beat_req", 32'(bus.mem_req_valid), 32'h0);
      chk("stray_beat_dout", bus.cpu_dout, 32'h0);
    end
    bus.mem_rdata_valid = 1'b0;
    bus.mem_rdata       = 32'h0;
    ld(32'h1000_0400, 32'h0000_0070, 1'b1);
    refill(32'h0000_0070, 1, 4);
    ld(32'h1000_0040, 32'h0000_0080, 1'b1);
    refill(32'h0000_0080, 1, 4);
    cyc();
    cyc();

    chk("loads_left", lq.size(), 32'h0);
    chk("reqs_left", mq.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
